// File: rtl/stream_blur_filter.sv
// Per-channel 3x3 / 5x5 binomial blur over a raster pixel stream, with bypass.
// Latency: 2 advancing cycles (S1 window update, S2 sum/normalise).
// Backpressure: in_ready = out_ready || !out_valid; a stalled output freezes the whole pipe.
module stream_blur_filter #(
    parameter int MAX_WIDTH = 320,
    parameter int CH_W      = 4,
    parameter int CHANNELS  = 3,
    localparam int PIX_W    = CH_W * CHANNELS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [9:0]       image_width,
    input  logic [8:0]       image_height,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic [PIX_W-1:0] out_data
);

    localparam int              AW     = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int              ACC_W  = CH_W + 8;
    localparam logic [9:0]      MAX_W  = 10'(MAX_WIDTH);
    localparam logic [CH_W-1:0] CH_MAX = '1;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_3X3    = 2'd1,
        MODE_5X5    = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    logic en;
    logic accept;

    assign en       = out_ready || !out_valid;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // ------------------------------------------------------------------
    // Frame position and per-frame latched configuration
    // ------------------------------------------------------------------
    logic [9:0] col_q, lat_w, cur_col, cur_w;
    logic [8:0] row_q, lat_h, cur_row, cur_h;
    mode_e      lat_mode, cur_mode;

    // An SOF pixel sees its own freshly sampled configuration, not the stale latch.
    always_comb begin
        cur_col  = col_q;
        cur_row  = row_q;
        cur_w    = lat_w;
        cur_h    = lat_h;
        cur_mode = lat_mode;
        if (in_sof) begin
            cur_col  = '0;
            cur_row  = '0;
            cur_w    = (image_width == 10'd0 || image_width > MAX_W) ? MAX_W : image_width;
            cur_h    = (image_height == 9'd0) ? 9'd511 : image_height;
            cur_mode = mode_e'(mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q    <= '0;
            row_q    <= '0;
            lat_w    <= MAX_W;
            lat_h    <= 9'd511;
            lat_mode <= MODE_BYPASS;
        end else if (accept) begin
            lat_w    <= cur_w;
            lat_h    <= cur_h;
            lat_mode <= cur_mode;
            if (cur_col == cur_w - 10'd1) begin
                col_q <= '0;
                row_q <= (cur_row == cur_h - 9'd1) ? 9'd0 : cur_row + 9'd1;
            end else begin
                col_q <= cur_col + 10'd1;
                row_q <= cur_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers and 5x5 window (S1). lb[0] holds the previous line.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] lb      [4][MAX_WIDTH];
    logic [PIX_W-1:0] win     [5][5];
    logic [PIX_W-1:0] col_new [5];
    logic [AW-1:0]    lb_addr;

    assign lb_addr = cur_col[AW-1:0];

    always_comb begin
        col_new[4] = in_data;
        for (int k = 0; k < 4; k++) begin
            col_new[3-k] = lb[k][lb_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][lb_addr] <= in_data;
            for (int k = 1; k < 4; k++) begin
                lb[k][lb_addr] <= lb[k-1][lb_addr];
            end
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][4] <= col_new[r];
            end
        end
    end

    logic  s1_vld, s1_sof, s1_edge3, s1_edge5;
    mode_e s1_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_sof   <= 1'b0;
            s1_edge3 <= 1'b1;
            s1_edge5 <= 1'b1;
            s1_mode  <= MODE_BYPASS;
        end else if (en) begin
            s1_vld <= in_valid;
            s1_sof <= in_valid && in_sof;
            if (accept) begin
                s1_mode  <= cur_mode;
                s1_edge3 <= (cur_row < 9'd2) || (cur_col < 10'd2);
                s1_edge5 <= (cur_row < 9'd4) || (cur_col < 10'd4);
            end
        end
    end

    // ------------------------------------------------------------------
    // Kernel sums and normalisation (S2)
    // ------------------------------------------------------------------
    function automatic logic [ACC_W-1:0] k3_w(input int i);
        return (i == 1) ? ACC_W'(2) : ACC_W'(1);
    endfunction

    function automatic logic [ACC_W-1:0] k5_w(input int i);
        case (i)
            0, 4:    return ACC_W'(1);
            1, 3:    return ACC_W'(4);
            default: return ACC_W'(6);
        endcase
    endfunction

    logic [PIX_W-1:0] filt3, filt5, raw_pix, sel_pix;

    assign raw_pix = win[4][4];

    // The 3x3 kernel is the bottom-right corner of the 5x5 window.
    always_comb begin : p_filter
        logic [ACC_W-1:0] acc3, acc5, px, q3, q5;
        acc3  = '0;
        acc5  = '0;
        px    = '0;
        q3    = '0;
        q5    = '0;
        filt3 = '0;
        filt5 = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            acc3 = '0;
            acc5 = '0;
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    px   = ACC_W'(win[r][c][ch*CH_W +: CH_W]);
                    acc5 = acc5 + px * (k5_w(r) * k5_w(c));
                    if (r >= 2 && c >= 2) begin
                        acc3 = acc3 + px * (k3_w(r - 2) * k3_w(c - 2));
                    end
                end
            end
            q3 = (acc3 + ACC_W'(8)) >> 4;
            q5 = (acc5 + ACC_W'(128)) >> 8;
            filt3[ch*CH_W +: CH_W] = (q3 > ACC_W'(CH_MAX)) ? CH_MAX : q3[CH_W-1:0];
            filt5[ch*CH_W +: CH_W] = (q5 > ACC_W'(CH_MAX)) ? CH_MAX : q5[CH_W-1:0];
        end
    end

    always_comb begin
        sel_pix = raw_pix;
        case (s1_mode)
            MODE_3X3: sel_pix = s1_edge3 ? raw_pix : filt3;
            MODE_5X5: sel_pix = s1_edge5 ? raw_pix : filt5;
            default:  sel_pix = raw_pix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= s1_vld;
            out_sof   <= s1_vld && s1_sof;
            if (s1_vld) begin
                out_data <= sel_pix;
            end
        end
    end

endmodule

// File: tb/tb_stream_blur_filter.sv
// Scoreboard bench for stream_blur_filter: directed frames, expected pixels queued at issue,
// a monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_stream_blur_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic [9:0]  image_width;
    logic [8:0]  image_height;
    logic        in_valid, in_ready, in_sof;
    logic [11:0] in_data;
    logic        out_valid, out_ready, out_sof;
    logic [11:0] out_data;

    always #5 clk = ~clk;

    stream_blur_filter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode         (mode),
        .image_width  (image_width),
        .image_height (image_height),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sof       (in_sof),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sof      (out_sof),
        .out_data     (out_data)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [12:0] exp_q[$];
    logic [12:0] got_q[$];
    logic [11:0] img [8][320];
    int          m_col = 0, m_row = 0, m_mode = 0, m_w = 320, m_h = 511;
    int          bp_cnt = 0;
    int          base, bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int wt(input int k, input int i);
        if (k == 3) return (i == 1) ? 2 : 1;
        case (i)
            0, 4:    return 1;
            1, 3:    return 4;
            default: return 6;
        endcase
    endfunction

    // Reference: direct 2-D convolution over the stored image rows.
    function automatic logic [11:0] model_px(input int r, input int c);
        int k, dv, s, v;
        logic [11:0] res;
        logic [11:0] p;
        k = (m_mode == 1) ? 3 : (m_mode == 2) ? 5 : 1;
        if (k == 1 || r < k - 1 || c < k - 1) return img[r % 8][c];
        dv  = (k == 3) ? 16 : 256;
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            s = 0;
            for (int i = 0; i < k; i++) begin
                for (int j = 0; j < k; j++) begin
                    p = img[(r - k + 1 + i) % 8][c - k + 1 + j];
                    s += wt(k, i) * wt(k, j) * int'(p[ch*4 +: 4]);
                end
            end
            v = (s + dv / 2) / dv;
            if (v > 15) v = 15;
            res[ch*4 +: 4] = 4'(v);
        end
        return res;
    endfunction

    function automatic logic [12:0] got_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 13'bx;
    endfunction

    // Called at a negedge; returns at the negedge after the pixel is accepted.
    task automatic send(input logic [11:0] d, input logic sof);
        int n;
        if (sof) begin
            m_col  = 0;
            m_row  = 0;
            m_mode = int'(mode);
            m_w    = (image_width == 10'd0 || image_width > 10'd320) ? 320 : int'(image_width);
            m_h    = (image_height == 9'd0) ? 511 : int'(image_height);
        end
        img[m_row % 8][m_col] = d;
        exp_q.push_back({sof, model_px(m_row, m_col)});
        if (m_col == m_w - 1) begin
            m_col = 0;
            m_row = (m_row == m_h - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Downstream ready: changes just after posedge so it is stable at negedge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_cnt > 0) begin
                out_ready = 1'b0;
                bp_cnt--;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: the negedge view is what the next posedge transfers.
    initial begin
        logic [12:0] e;
        logic [13:0] held;
        logic        held_vld;
        held_vld = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (held_vld)
                    check("stall_hold", 32'({out_valid, out_sof, out_data}), 32'(held));
                held_vld = 1'b0;
                if (out_valid && !out_ready) begin
                    held_vld = 1'b1;
                    held     = {1'b1, out_sof, out_data};
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                end
                if (out_valid && out_ready) begin
                    got_q.push_back({out_sof, out_data});
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got 0x%0h expected none", {out_sof, out_data});
                    end else begin
                        e = exp_q.pop_front();
                        check("scoreboard", 32'({out_sof, out_data}), 32'(e));
                    end
                end
            end else begin
                held_vld = 1'b0;
            end
        end
    end

    initial begin
        rst_n        = 1'b1;
        mode         = 2'd0;
        image_width  = 10'd16;
        image_height = 9'd8;
        in_valid     = 1'b0;
        in_sof       = 1'b0;
        in_data      = '0;
        #3 rst_n = 1'b0;
        #9;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sof",   32'(out_sof),   32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Bypass, hand-checked values
        base = got_q.size();
        send(12'h123, 1'b1);
        send(12'h456, 1'b0);
        send(12'h789, 1'b0);
        drain();
        check("bypass_px0", 32'(got_at(base)),     32'h1123);
        check("bypass_px1", 32'(got_at(base + 1)), 32'h0456);
        check("bypass_px2", 32'(got_at(base + 2)), 32'h0789);

        // 3x3 flat fields
        mode = 2'd1;
        base = got_q.size();
        for (int i = 0; i < 128; i++) send(12'hFFF, i == 0);
        for (int i = 0; i < 128; i++) send(12'h888, i == 0);
        drain();
        check("flat_count", 32'(got_q.size() - base), 32'd256);
        bad = 0;
        for (int i = 0; i < 128; i++) if (got_at(base + i) !== {i == 0, 12'hFFF}) bad++;
        check("flat_fff_bad", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 0; i < 128; i++) if (got_at(base + 128 + i) !== {i == 0, 12'h888}) bad++;
        check("flat_888_bad", 32'(bad), 32'd0);

        // 5x5 impulse at (2,2)
        mode = 2'd2;
        base = got_q.size();
        for (int i = 0; i < 128; i++) send((i == 34) ? 12'hF00 : 12'h000, i == 0);
        drain();
        check("imp_raw_2_2", 32'(got_at(base + 34)),  32'h0F00);
        check("imp_4_4",     32'(got_at(base + 68)),  32'h0200);
        check("imp_4_5",     32'(got_at(base + 69)),  32'h0100);
        check("imp_5_5",     32'(got_at(base + 85)),  32'h0100);
        check("imp_6_6",     32'(got_at(base + 102)), 32'h0000);

        // Backpressure mid-line
        mode = 2'd1;
        for (int i = 0; i < 128; i++) begin
            if (i == 40) bp_cnt = 5;
            send(12'($urandom), i == 0);
        end
        drain();

        // Mode/size change mid-frame is ignored; width 400 behaves as 320
        mode        = 2'd1;
        image_width = 10'd400;
        for (int i = 0; i < 1000; i++) begin
            if (i == 10) begin
                mode        = 2'd2;
                image_width = 10'd16;
            end
            send(12'((i * 37) ^ (i >> 2)), i == 0);
        end
        drain();

        // Reset mid-frame, then a fresh 5x5 frame
        mode        = 2'd1;
        image_width = 10'd16;
        for (int i = 0; i < 50; i++) send(12'($urandom), i == 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data",  32'(out_data),  32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mode = 2'd2;
        for (int i = 0; i < 96; i++) send(12'($urandom), i == 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_blur_filter.md
STREAM_BLUR_FILTER -- requirements
Module: stream_blur_filter

Interface
REQ-001 SHALL have parameter MAX_WIDTH, default 320, meaning maximum line length and depth of each line buffer.
REQ-002 SHALL have parameter CH_W, default 4, meaning bits per colour channel.
REQ-003 SHALL have parameter CHANNELS, default 3, meaning channels per pixel (RGB); pixel width PIX_W = CH_W*CHANNELS (12 at defaults).
REQ-004 SHALL have one clock, clk, and asynchronous active-low reset rst_n; no other clock or reset exists.
REQ-005 Ports, in order:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- mode  in  2  0 bypass, 1 3x3, 2 5x5, 3 treated as bypass
- image_width  in  10  active pixels per line
- image_height  in  9  active lines per frame
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts pixel this cycle
- in_sof  in  1  first pixel of frame, qualified by in_valid
- in_data  in  PIX_W  pixel, channel 0 in LSBs
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_sof  out  1  in_sof delayed with its pixel
- out_data  out  PIX_W  filtered pixel

Function
REQ-006 SHALL accept a pixel when in_valid && in_ready; SHALL emit a pixel when out_valid && out_ready.
REQ-007 SHALL use a 2-stage pipeline (S1 window update, S2 sum/normalise) advancing on en = out_ready || !out_valid; in_ready SHALL equal en.
REQ-008 Latency SHALL be 2 advancing cycles from accept to out_valid; exactly one output per accepted input, order preserved, bubbles propagated.
REQ-009 While out_valid && !out_ready, out_data, out_sof, out_valid SHALL hold stable and no internal state SHALL change.
REQ-010 SHALL store 4 line buffers of MAX_WIDTH pixels plus a 5x5 window register; line buffers written only on accept.
REQ-011 col/row counters SHALL advance per accept: col wraps at width-1 to 0 with row+1; row wraps at height-1 to 0.
REQ-012 An accepted pixel with in_sof=1 SHALL be treated as col 0, row 0 regardless of counter state and SHALL latch mode, image_width, image_height for the frame.
REQ-013 Latched width of 0 or > MAX_WIDTH SHALL be used as MAX_WIDTH; height of 0 SHALL be used as 511.
REQ-014 Mode/size changes between SOFs SHALL have no effect.
REQ-015 Filtering SHALL be per channel, independent; no cross-channel carry.
REQ-016 3x3 kernel SHALL be binomial [1 2 1;2 4 2;1 2 1], sum 16; 5x5 SHALL be outer product of [1 4 6 4 1], sum 256.
REQ-017 Accumulators SHALL be CH_W+8 bits minimum; result = (sum + half_divisor) >> log2(divisor), rounding half up, saturated to 2^CH_W-1.
REQ-018 Window SHALL have the current accepted pixel at bottom-right; output is the filtered window (image shifted by kernel radius).
REQ-019 If row < K-1 or col < K-1 (K kernel size), out_data SHALL be the raw accepted pixel unmodified.
REQ-020 Bypass mode SHALL output in_data unchanged with the same 2-cycle latency and handshake.
REQ-021 SOF mid-line SHALL restart counters immediately; stale line-buffer contents SHALL not be used (REQ-019 applies).

Reset
REQ-022 On rst_n low, asynchronously: out_valid=0, out_sof=0, out_data=0, counters=0, pipeline valid flags=0, latched mode=0 (bypass), latched width=MAX_WIDTH, latched height=511.
REQ-023 in_ready SHALL be 1 during and after reset (out_valid=0).
REQ-024 Line buffer contents SHALL not require reset; rst_n mid-frame SHALL discard in-flight pixels; next frame begins at next in_sof.

Verification
REQ-025 Bypass: mode=0, width 16, 3 pixels 0x123,0x456,0x789, out_ready=1 -> same values 2 cycles later, out_sof on first.
REQ-026 3x3 flat: width 16 height 8, all pixels 0xFFF -> every output 0xFFF; all 0x888 -> 0x888.
REQ-027 5x5 impulse: all 0 except (row 2,col 2)=0xF00 -> output at input (4,4) has ch2 = (15*36+128)>>8 = 2, i.e. 0x200; border rows/cols 0-3 raw.
REQ-028 Backpressure: out_ready low 5 cycles mid-line -> in_ready low, out_data stable, no loss/duplication vs reference model.
REQ-029 Mode change: set mode=2 mid-frame -> ignored until next in_sof; width=400 latched -> behaves as 320.
REQ-030 Reset mid-frame: rst_n pulse low after 50 pixels -> out_valid=0 immediately; new frame after SOF matches model.
